// File: rtl/apb_spi_regif.sv
// apb_spi_regif: APB slave register block for the SPI master.
//   Holds CTRL, a TX FIFO feeding the shifter, an RX FIFO filled by the
//   shifter and a STATUS register. Every transfer is stretched by
//   WAIT_STATES PREADY-low access cycles.
// Ports:
//   PCLK / PRESET            clock, synchronous active-high reset
//   PADDR/PWDATA/PSEL/PENABLE/PWRITE -> PRDATA/PREADY   APB slave side
//   tx_data/tx_valid/tx_ready  TX FIFO head (fall-through) to the shifter
//   rx_data/rx_valid           RX push strobe from the shifter (no backpressure)
//   ctrl_en/cpol/cpha/div      CTRL fields; irq = CTRL[3] && RX not empty
// Optional build macro APB_SPI_REGIF_PSLVERR_EN adds PSLVERR, flagging
//   unmapped accesses, TXDATA writes while full and RXDATA reads while empty.
module apb_spi_regif #(
  parameter int unsigned SEL_INDEX   = 0,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [15:0] PADDR,
  input  logic [15:0] PWDATA,
  input  logic [15:0] PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  output logic [15:0] PRDATA,
  output logic        PREADY,
`ifdef APB_SPI_REGIF_PSLVERR_EN
  output logic        PSLVERR,
`endif
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        ctrl_en,
  output logic        ctrl_cpol,
  output logic        ctrl_cpha,
  output logic [7:0]  ctrl_div,
  output logic        irq
);

  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  DEPTH_C = 4'(FIFO_DEPTH);
  localparam logic [3:0]  WS_C    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d, wdata_q, wdata_d, prdata_q, prdata_d, ctrl_q, ctrl_d;
  logic          write_q, write_d, pready_q, pready_d, irq_q, irq_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   tx_mem_q [FIFO_DEPTH];
  logic [15:0]   tx_mem_d [FIFO_DEPTH];
  logic [15:0]   rx_mem_q [FIFO_DEPTH];
  logic [15:0]   rx_mem_d [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [3:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
`ifdef APB_SPI_REGIF_PSLVERR_EN
  logic          pslverr_q, pslverr_d, err;
`endif

  logic          sel, complete, tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop, write_sel;
  logic          hit_ctrl, hit_tx, hit_rx, hit_stat;
  logic [15:0]   addr_sel, status_val, rd_val;
  logic          unused_psel;

  assign sel         = PSEL[SEL_INDEX];
  assign unused_psel = ^PSEL;
  assign tx_full     = (tx_cnt_q == DEPTH_C);
  assign tx_empty    = (tx_cnt_q == 4'd0);
  assign rx_full     = (rx_cnt_q == DEPTH_C);
  assign rx_empty    = (rx_cnt_q == 4'd0);

  // In IDLE the read value is taken straight from the setup-phase bus
  // (zero-wait-state case); afterwards from the captured transfer.
  always_comb begin
    addr_sel   = (state_q == IDLE) ? PADDR  : addr_q;
    write_sel  = (state_q == IDLE) ? PWRITE : write_q;
    hit_ctrl   = (addr_sel == BASE_ADDR);
    hit_tx     = (addr_sel == BASE_ADDR + 16'h4);
    hit_rx     = (addr_sel == BASE_ADDR + 16'h6);
    hit_stat   = (addr_sel == BASE_ADDR + 16'h8);
    status_val = {rx_cnt_q, tx_cnt_q, 2'b00, rx_ovf_q, tx_ovf_q,
                  rx_full, rx_empty, tx_full, tx_empty};
    rd_val     = 16'h0000;
    if (!write_sel) begin
      if (hit_ctrl)                rd_val = ctrl_q;
      else if (hit_rx && !rx_empty) rd_val = rx_mem_q[rx_rd_q];
      else if (hit_stat)           rd_val = status_val;
    end
`ifdef APB_SPI_REGIF_PSLVERR_EN
    err = !(hit_ctrl || hit_tx || hit_rx || hit_stat) ||
          (hit_tx && write_sel && tx_full) || (hit_rx && !write_sel && rx_empty);
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    pready_d = pready_q;
    prdata_d = prdata_q;
    ctrl_d   = ctrl_q;
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovf_d = rx_ovf_q;
`ifdef APB_SPI_REGIF_PSLVERR_EN
    pslverr_d = pslverr_q;
`endif

    complete = (state_q == ACCESS) && sel && PENABLE && pready_q;
    tx_push  = complete && write_q && hit_tx && !tx_full;
    tx_pop   = !tx_empty && tx_ready;
    rx_pop   = complete && !write_q && hit_rx && !rx_empty;
    rx_push  = rx_valid && !rx_full;

    unique case (state_q)
      IDLE: begin
        pready_d = 1'b0;
        prdata_d = 16'h0000;
        if (sel && !PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          cnt_d   = WS_C;
          state_d = ACCESS;
          if (WS_C == 4'd0) begin
            pready_d = 1'b1;
            prdata_d = rd_val;
`ifdef APB_SPI_REGIF_PSLVERR_EN
            pslverr_d = err;
`endif
          end
        end
      end
      ACCESS: begin
        if (!sel || complete) begin
          // Abort (no commit) or completion: both release the bus signals.
          state_d  = complete ? HOLD : IDLE;
          pready_d = 1'b0;
          prdata_d = 16'h0000;
`ifdef APB_SPI_REGIF_PSLVERR_EN
          pslverr_d = 1'b0;
`endif
        end else if (!pready_q && cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d = 1'b1;
            prdata_d = rd_val;
`ifdef APB_SPI_REGIF_PSLVERR_EN
            pslverr_d = err;
`endif
          end
        end
      end
      HOLD: if (!sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Commit side effects, once, on the completion edge.
    if (complete && write_q) begin
      if (hit_ctrl) ctrl_d = wdata_q;
      if (hit_tx && tx_full) tx_ovf_d = 1'b1;
      if (hit_stat) begin
        if (wdata_q[4]) tx_ovf_d = 1'b0;
        if (wdata_q[5]) rx_ovf_d = 1'b0;
      end
    end
    // A fresh overflow beats a same-cycle clear.
    if (rx_valid && rx_full) rx_ovf_d = 1'b1;

    if (tx_push) begin
      tx_mem_d[tx_wr_q] = wdata_q;
      tx_wr_d = tx_wr_q + PW'(1);
    end
    if (tx_pop) tx_rd_d = tx_rd_q + PW'(1);
    if (rx_push) begin
      rx_mem_d[rx_wr_q] = rx_data;
      rx_wr_d = rx_wr_q + PW'(1);
    end
    if (rx_pop) rx_rd_d = rx_rd_q + PW'(1);
    tx_cnt_d = tx_cnt_q + {3'b000, tx_push} - {3'b000, tx_pop};
    rx_cnt_d = rx_cnt_q + {3'b000, rx_push} - {3'b000, rx_pop};

    irq_d = ctrl_d[3] && (rx_cnt_d != 4'd0);
  end

  always_ff @(posedge PCLK) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      ctrl_q   <= '0;
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
`ifdef APB_SPI_REGIF_PSLVERR_EN
      pslverr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      ctrl_q   <= ctrl_d;
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovf_q <= rx_ovf_d;
      irq_q    <= irq_d;
`ifdef APB_SPI_REGIF_PSLVERR_EN
      pslverr_q <= pslverr_d;
`endif
    end
  end

  assign PREADY    = pready_q;
  assign PRDATA    = prdata_q;
`ifdef APB_SPI_REGIF_PSLVERR_EN
  assign PSLVERR   = pslverr_q;
`endif
  assign tx_data   = tx_mem_q[tx_rd_q];
  assign tx_valid  = !tx_empty;
  assign ctrl_en   = ctrl_q[0];
  assign ctrl_cpol = ctrl_q[1];
  assign ctrl_cpha = ctrl_q[2];
  assign ctrl_div  = ctrl_q[15:8];
  assign irq       = irq_q;

endmodule
